bf_uart_tx: RTL and testbench
=============================

# bf_uart_tx

Output stage of the Brainfuck CPU: consumes the core's per-cycle output strobe (`cout`) and cell value (`next_ram_val`), buffers characters in a small synchronous FIFO and serializes them as 8N1 UART on the board TX pin. It also drives a back-pressure signal that the top level ANDs into the core's `enable`. This guarantees no `.` character is ever lost while the line is busy.

## Interface
- `DATA_WIDTH`, 8: character width; must equal the core's data width.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥4.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `out_valid`  in  1  character strobe from core `cout`; one character per high cycle.
- `out_data`  in  DATA_WIDTH  character from core `next_ram_val`; sampled when `out_valid`=1.
- `stall`  out  1  combinational; high = top level must drive core `enable` low.
- `tx`  out  1  registered UART line, idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `overflow`  out  1  sticky; set on a push attempt while the FIFO is full.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `out_valid`=1 and FIFO not full → write `out_data`, `level`+1. If full → drop the character and set `overflow`. Cleared only by reset.
- Stall: `stall` = (`level` + `out_valid`) ≥ FIFO_DEPTH−1. This accounts for the core's one-cycle registered `cout`. With `stall` honoured, `overflow` never sets.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. `tx` stays 1.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit DATA_WIDTH−1, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the final cycle, if the FIFO is non-empty, pop and go directly to START (gapless back-to-back). Otherwise go to IDLE.
- Baud counter: loads CLKS_PER_BIT−1 on each state or bit entry and decrements to 0. A bit ends on the cycle the counter is 0.
- Simultaneous push and pop: `level` is unchanged and both take effect. A push into an empty FIFO is not poppable until the next cycle.
- Pointer wrap: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from `level`.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `level`=0, `stall`=`out_valid`-dependent (0 when FIFO_DEPTH≥4 and `out_valid`=0). FSM=IDLE, pointers=0.
- Reset mid-frame: `tx` is 1 on the cycle after the `rst_n`=0 edge. The FIFO contents are discarded and the partial frame is abandoned.
- Push latency: `out_valid` at edge k → `level` updated after edge k.
- First-character latency: push at edge k → pop at edge k+1 → `tx` falls after edge k+2.
- Frame length: exactly 10·CLKS_PER_BIT cycles, LSB first.
- Back-to-back frames: the next start bit immediately follows the stop bit, with no idle cycle.
- `busy` deasserts on the cycle the FSM returns to IDLE with the FIFO empty.

## Structure
- Shared package `bf_pkg`:
  - UART FSM state enum `uart_state_t` (IDLE/START/DATA/STOP).
  - Default `BF_CLKS_PER_BIT` constant.
  - Opcode constants, relocated from the core's defines so both blocks share them.
- One sub-module: `bf_sync_fifo` (DATA_WIDTH, DEPTH; push/pop/full/empty/level, synchronous active-low reset). The FSM and baud counter live in `bf_uart_tx`.

## Test plan
Benches use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single character: 0x41 pulsed for one cycle after reset. `tx` low 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), then high 4 cycles. `busy` is low after 40+2 cycles.
- Burst with honoured stall: `out_valid` held high while `stall` is low, sending 0x30..0x39. `stall` rises at `level`+`out_valid`≥3. All ten frames are gapless, in order, and `overflow` stays 0.
- Overflow: `out_valid` forced high for 8 consecutive cycles, ignoring `stall`. `level` saturates at 4, `overflow` goes to 1 and stays, and the dropped characters never appear on `tx`.
- Simultaneous push and pop: push at the final STOP cycle with `level`=1. `level` stays 1, and the next start bit follows immediately.
- Reset mid-frame: `rst_n` low during DATA bit 3. `tx`=1, `level`=0, `busy`=0, `overflow`=0 next cycle, and the next push transmits cleanly.
- Pointer wrap: 12 characters sent with `stall` honoured. The decoded sequence matches the input exactly.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants and types for the Brainfuck CPU blocks
//
// Contents:
//   uart_state_t     transmitter FSM state encoding (IDLE/START/DATA/STOP)
//   BF_CLKS_PER_BIT  default baud divider (50 MHz / 115200)
//   OP_*             Brainfuck opcode characters shared by the core and I/O blocks
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int BF_CLKS_PER_BIT = 434;

  localparam logic [7:0] OP_PTR_INC = 8'h3E;  // '>'
  localparam logic [7:0] OP_PTR_DEC = 8'h3C;  // '<'
  localparam logic [7:0] OP_VAL_INC = 8'h2B;  // '+'
  localparam logic [7:0] OP_VAL_DEC = 8'h2D;  // '-'
  localparam logic [7:0] OP_OUT     = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN      = 8'h2C;  // ','
  localparam logic [7:0] OP_LOOP_B  = 8'h5B;  // '['
  localparam logic [7:0] OP_LOOP_E  = 8'h5D;  // ']'

endpackage

// File: rtl/bf_uart_tx_if.sv
// rtl/bf_uart_tx_if.sv - character stream from the core into the UART output stage
//
// Signals:
//   out_valid  core -> uart  one character per high cycle (core cout)
//   out_data   core -> uart  character value (core next_ram_val)
//   stall      uart -> core  back-pressure; top level ANDs its inverse into core enable
interface bf_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  stall;

  modport master (output out_valid, output out_data, input stall);
  modport slave  (input out_valid, input out_data, output stall);
endinterface

// File: rtl/bf_sync_fifo.sv
// rtl/bf_sync_fifo.sv - small synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_data       write request (ignored when full)
//   pop, pop_data         read request (ignored when empty); pop_data shows the head
//   full, empty, level    status derived from the occupancy counter
module bf_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap naturally; full/empty come from the counter, so no extra pointer bit.
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/bf_uart_tx.sv
// rtl/bf_uart_tx.sv - buffered 8N1 UART transmitter for the core's '.' output
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   core         slave side of bf_uart_tx_if (out_valid/out_data in, stall out)
//   tx           registered UART line, idle high
//   busy         FIFO non-empty or frame in progress
//   overflow     sticky: a character arrived while the FIFO was full
//   level        FIFO occupancy
module bf_uart_tx
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = BF_CLKS_PER_BIT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bf_uart_tx_if.slave                  core,
  output logic                         tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = LW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  uart_state_t           state, state_n;
  logic [CW-1:0]         baud_cnt, baud_cnt_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  tx_n;
  logic                  pop;
  logic                  bit_done;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  bf_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (core.out_valid),
    .push_data (core.out_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Threshold is one below depth: the core's cout is registered, so one more
  // character can still arrive after enable is pulled low.
  assign core.stall = ({1'b0, level} + SW'(core.out_valid)) >= SW'(FIFO_DEPTH - 1);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign bit_done   = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
      if (core.out_valid && fifo_full) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    pop        = 1'b0;
    tx_n       = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_n    = fifo_head;
          baud_cnt_n = CNT_LOAD;
          state_n    = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_done) begin
          bit_idx_n  = '0;
          baud_cnt_n = CNT_LOAD;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - CW'(1);
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_done) begin
          shift_n    = shift >> 1;
          baud_cnt_n = CNT_LOAD;
          if (bit_idx == LAST_BIT) state_n = STOP;
          else                     bit_idx_n = bit_idx + IW'(1);
        end else begin
          baud_cnt_n = baud_cnt - CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          // Pop on the last stop cycle so the next start bit follows with no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_n    = fifo_head;
            baud_cnt_n = CNT_LOAD;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bf_uart_tx.sv
// tb/tb_bf_uart_tx.sv - self-checking bench for bf_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_bf_uart_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  bf_uart_tx_if #(.DATA_WIDTH(DW)) core_if ();

  bf_uart_tx #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (core_if),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errs = 0;
  int         cyc = 0;
  int         rx_cnt = 0;
  logic [7:0] sb_q[$];
  int         start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int t = 0;
    while (busy && t < bound) begin
      step();
      t++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (3) step();
  endtask

  task automatic check_gaps(input string tag);
    int bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != FRAME) bad++;
    chk({tag, "_gapless"}, 32'(bad), 32'd0);
  endtask

  // Pushes n characters, only driving out_valid when the DUT's stall allows it.
  task automatic burst(input int n, input bit rnd, input string tag);
    int         sent = 0;
    int         t = 0;
    int         rx0;
    logic [7:0] d;
    rx0 = rx_cnt;
    start_q.delete();
    while (sent < n && t < 2000) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(8'h30 + sent);
      core_if.out_valid = 1'b1;
      core_if.out_data  = d;
      #1;
      if (core_if.stall) core_if.out_valid = 1'b0;
      else begin
        sb_q.push_back(d);
        sent++;
      end
      step();
      t++;
    end
    core_if.out_valid = 1'b0;
    chk({tag, "_sent"}, 32'(sent), 32'(n));
    wait_idle(tag, 60 * n + 100);
    chk({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'(n));
    chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_no_overflow"}, 32'(overflow), 32'd0);
    check_gaps(tag);
  endtask

  // UART receiver: checks each bit is stable for CPB samples and scores the byte.
  initial begin : rx_mon
    int         start_cyc;
    bit         ok;
    bit         aborted;
    logic [7:0] byte_v;
    int         b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        start_cyc = cyc;
        ok = 1'b1;
        aborted = 1'b0;
        byte_v = '0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          b = c / CPB;
          if (b == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (b <= 8) begin
            if (c % CPB == 0) byte_v[b-1] = tx;
            else if (tx !== byte_v[b-1]) ok = 1'b0;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
          end
        end
        if (!aborted) begin
          chk("rx_frame_shape", 32'(ok), 32'd1);
          chk("rx_expected_pending", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) chk("rx_data", 32'(byte_v), 32'(sb_q.pop_front()));
          rx_cnt++;
          start_q.push_back(start_cyc);
        end
      end
    end
  end

  initial begin : stim
    int         rx0;
    logic [9:0] frame_w;
    int         exp_lvl[8];

    core_if.out_valid = 1'b0;
    core_if.out_data  = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_stall_idle", 32'(core_if.stall), 32'd0);
    core_if.out_valid = 1'b1;
    #1;
    chk("rst_stall_valid", 32'(core_if.stall), 32'd0);
    core_if.out_valid = 1'b0;
    step();

    // Single character 0x41
    rx0 = rx_cnt;
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h41;
    sb_q.push_back(8'h41);
    step();
    core_if.out_valid = 1'b0;
    chk("single_level_push", 32'(level), 32'd1);
    chk("single_tx_idle", 32'(tx), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    step();
    chk("single_level_pop", 32'(level), 32'd0);
    chk("single_tx_before_start", 32'(tx), 32'd1);
    step();
    frame_w = 10'b1_0100_0001_0;
    for (int j = 0; j < FRAME; j++) begin
      if (j % CPB == 1) chk("single_bit", 32'(tx), 32'(frame_w[j / CPB]));
      if (j == 38) chk("single_busy_stop", 32'(busy), 32'd1);
      if (j == 39) chk("single_busy_low", 32'(busy), 32'd0);
      step();
    end
    repeat (3) step();
    chk("single_rx_count", 32'(rx_cnt - rx0), 32'd1);
    chk("single_sb_drained", 32'(sb_q.size()), 32'd0);

    // Burst with honoured stall, 0x30..0x39
    burst(10, 1'b0, "burst");

    // Overflow: out_valid forced high for 8 cycles
    rx0 = rx_cnt;
    exp_lvl = '{1, 1, 2, 3, 4, 4, 4, 4};
    for (int i = 0; i < 8; i++) begin
      core_if.out_valid = 1'b1;
      core_if.out_data  = 8'(8'h50 + i);
      if (i < 5) sb_q.push_back(8'(8'h50 + i));
      step();
      chk("ovf_level", 32'(level), 32'(exp_lvl[i]));
      if (i < 7) chk("ovf_stall", 32'(core_if.stall), 32'(exp_lvl[i] + 1 >= 3));
      if (i == 4) chk("ovf_not_yet", 32'(overflow), 32'd0);
    end
    core_if.out_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf", 400);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_rx_count", 32'(rx_cnt - rx0), 32'd5);
    chk("ovf_sb_drained", 32'(sb_q.size()), 32'd0);

    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("ovf_cleared_by_reset", 32'(overflow), 32'd0);

    // Simultaneous push and pop at the final stop cycle
    rx0 = rx_cnt;
    start_q.delete();
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h61;
    sb_q.push_back(8'h61);
    step();
    core_if.out_valid = 1'b0;
    step();
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h62;
    sb_q.push_back(8'h62);
    step();
    core_if.out_valid = 1'b0;
    chk("pp_level_b", 32'(level), 32'd1);
    repeat (38) step();
    chk("pp_level_before", 32'(level), 32'd1);
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h63;
    sb_q.push_back(8'h63);
    step();
    core_if.out_valid = 1'b0;
    chk("pp_level_same", 32'(level), 32'd1);
    chk("pp_last_stop", 32'(tx), 32'd1);
    step();
    chk("pp_next_start", 32'(tx), 32'd0);
    wait_idle("pp", 300);
    chk("pp_rx_count", 32'(rx_cnt - rx0), 32'd3);
    chk("pp_sb_drained", 32'(sb_q.size()), 32'd0);
    check_gaps("pp");

    // Reset during DATA bit 3
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h71;
    sb_q.push_back(8'h71);
    step();
    core_if.out_data  = 8'h72;
    sb_q.push_back(8'h72);
    step();
    core_if.out_valid = 1'b0;
    repeat (17) step();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    chk("mid_level_pre", 32'(level), 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    step();
    chk("mid_tx", 32'(tx), 32'd1);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (45) step();
    rx0 = rx_cnt;
    core_if.out_valid = 1'b1;
    core_if.out_data  = 8'h55;
    sb_q.push_back(8'h55);
    step();
    core_if.out_valid = 1'b0;
    wait_idle("mid_after", 100);
    chk("mid_after_rx_count", 32'(rx_cnt - rx0), 32'd1);
    chk("mid_after_sb_drained", 32'(sb_q.size()), 32'd0);

    // Pointer wrap: 12 random characters with honoured stall
    burst(12, 1'b1, "wrap");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
